// File: rtl/wide_add_pkg.sv
// Shared types and width helpers for the wide_add_sequencer slice.
// Sequencer FSM states plus index/counter width functions.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wait counter must hold the value LAT.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Request/result bus plus adder-side slice bus for wide_add_sequencer.
// Optional `ovf` signal exists only when WIDE_ADD_OVF_EN is defined.
interface wide_add_sequencer_if #(
  parameter int W = 16,
  parameter int N = 4
);
  logic             start;
  logic [N*W-1:0]   op_a;
  logic [N*W-1:0]   op_b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [N*W-1:0]   result;
  logic             c_out;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_c_in;
  logic [W-1:0]     add_sum;
  logic             add_c_out;

`ifdef WIDE_ADD_OVF_EN
  logic             ovf;

  modport slave (
    input  start, op_a, op_b, c_in, add_sum, add_c_out,
    output busy, done, result, c_out, ovf, add_a, add_b, add_c_in
  );

  modport master (
    output start, op_a, op_b, c_in, add_sum, add_c_out,
    input  busy, done, result, c_out, ovf, add_a, add_b, add_c_in
  );
`else
  modport slave (
    input  start, op_a, op_b, c_in, add_sum, add_c_out,
    output busy, done, result, c_out, add_a, add_b, add_c_in
  );

  modport master (
    output start, op_a, op_b, c_in, add_sum, add_c_out,
    input  busy, done, result, c_out, add_a, add_b, add_c_in
  );
`endif

endinterface

// File: rtl/adder_top.sv
// Registered W-bit adder with carry in/out; result appears LAT clocks
// after the operands change.
module adder_top #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [LAT-1:0][W:0] pipe_q;
  logic [LAT-1:0][W:0] pipe_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    pipe_d    = pipe_q;
    pipe_d[0] = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign {c_out, sum} = pipe_q[LAT-1];

endmodule

// File: rtl/wide_add_slice_regs.sv
// N x W operand/result slice register file: load both operands at once,
// read A[k]/B[k] by index, write result[k] by index.
module wide_add_slice_regs #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N*W-1:0]   op_a,
  input  logic [N*W-1:0]   op_b,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_a,
  output logic [W-1:0]     rd_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  output logic [N*W-1:0]   result
);

  logic [N-1:0][W-1:0] a_q, a_d;
  logic [N-1:0][W-1:0] b_q, b_d;
  logic [N-1:0][W-1:0] res_q, res_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (load) begin
      a_d   = op_a;
      b_d   = op_b;
      res_d = '0;
    end else if (wr_en) begin
      res_d[wr_idx] = wr_data;
    end
  end

  // NOTE: operand storage has no reset; it is always loaded before it is read, so only the visible result is cleared.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign rd_a   = a_q[rd_idx];
  assign rd_b   = b_q[rd_idx];
  assign result = res_q;

endmodule

// File: rtl/wide_add_sequencer.sv
// Streams an N x W-bit add through a W-bit registered adder, LS slice first,
// rippling carry between slices. WIDE_ADD_OVF_EN adds a signed-overflow flag.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus
);

  localparam int               IDX_W    = idx_width(N);
  localparam int               CNT_W    = cnt_width(LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [W-1:0]     add_a_q, add_a_d;
  logic [W-1:0]     add_b_q, add_b_d;
  logic             add_c_in_q, add_c_in_d;

  logic             load;
  logic             wr_en;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic [N*W-1:0]   result;

`ifdef WIDE_ADD_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  wide_add_slice_regs #(
    .W     (W),
    .N     (N),
    .IDX_W (IDX_W)
  ) u_slices (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .op_a    (bus.op_a),
    .op_b    (bus.op_b),
    .rd_idx  (k_q),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .wr_en   (wr_en),
    .wr_idx  (k_q),
    .wr_data (bus.add_sum),
    .result  (result)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    c_out_d    = c_out_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_c_in_d = add_c_in_q;
    load       = 1'b0;
    wr_en      = 1'b0;
`ifdef WIDE_ADD_OVF_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    ovf_d      = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          k_d     = '0;
          carry_d = bus.c_in;
          c_out_d = 1'b0;
`ifdef WIDE_ADD_OVF_EN
          a_msb_d = bus.op_a[N*W-1];
          b_msb_d = bus.op_b[N*W-1];
          ovf_d   = 1'b0;
`endif
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        add_a_d    = rd_a;
        add_b_d    = rd_b;
        add_c_in_d = carry_q;
        cnt_d      = CNT_LOAD;
        state_d    = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          wr_en   = 1'b1;
          carry_d = bus.add_c_out;
          if (k_q == LAST_IDX) begin
            // Final carry/flag load on the way into DONE so they are valid alongside done.
            c_out_d = bus.add_c_out;
`ifdef WIDE_ADD_OVF_EN
            ovf_d   = (a_msb_q == b_msb_q) && (bus.add_sum[W-1] != a_msb_q);
`endif
            state_d = DONE;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      c_out_q    <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_c_in_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      c_out_q    <= c_out_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_c_in_q <= add_c_in_d;
    end
  end

`ifdef WIDE_ADD_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  // Operands go out combinationally during ISSUE so the adder samples them at
  // ISSUE's closing edge; the held copy keeps them stable through WAIT.
  assign bus.add_a    = (state_q == ISSUE) ? rd_a    : add_a_q;
  assign bus.add_b    = (state_q == ISSUE) ? rd_b    : add_b_q;
  assign bus.add_c_in = (state_q == ISSUE) ? carry_q : add_c_in_q;

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result;
  assign bus.c_out  = c_out_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer driving a real adder_top:
// directed vector table, corner sequences, and randomized adds vs. a 65-bit model.
module tb_wide_add_sequencer;

  localparam int W       = 16;
  localparam int N       = 4;
  localparam int LAT     = 1;
  localparam int TW      = N * W;
  localparam int EXP_LAT = N * (LAT + 1) + 1;
  localparam int BUDGET  = 4 * EXP_LAT;
  localparam int NVEC    = 8;

  typedef logic [TW-1:0] word_t;

  typedef struct {
    word_t a;
    word_t b;
    logic  cin;
    word_t exp_r;
    logic  exp_c;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wide_add_sequencer_if #(.W(W), .N(N)) bus ();

  wide_add_sequencer #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  adder_top #(.W(W), .LAT(LAT)) u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.add_a),
    .b     (bus.add_b),
    .c_in  (bus.add_c_in),
    .sum   (bus.add_sum),
    .c_out (bus.add_c_out)
  );

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic one bit wider than the operands.
  function automatic logic [TW:0] model_add(input word_t a, input word_t b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
  endfunction

`ifdef WIDE_ADD_OVF_EN
  // Signed overflow: exact signed sum falls outside the TW-bit signed range.
  function automatic logic model_ovf(input word_t a, input word_t b, input logic cin);
    logic signed [TW+1:0] s;
    s = $signed({{2{a[TW-1]}}, a}) + $signed({{2{b[TW-1]}}, b}) + $signed({{(TW+1){1'b0}}, cin});
    return (s > $signed({3'b000, {(TW-1){1'b1}}})) || (s < $signed({3'b111, {(TW-1){1'b0}}}));
  endfunction
`endif

  task automatic check_cleared(input string name);
    check({name, "_busy"},     TW'(bus.busy),     '0);
    check({name, "_done"},     TW'(bus.done),     '0);
    check({name, "_result"},   bus.result,        '0);
    check({name, "_c_out"},    TW'(bus.c_out),    '0);
    check({name, "_add_a"},    TW'(bus.add_a),    '0);
    check({name, "_add_b"},    TW'(bus.add_b),    '0);
    check({name, "_add_c_in"}, TW'(bus.add_c_in), '0);
`ifdef WIDE_ADD_OVF_EN
    check({name, "_ovf"},      TW'(bus.ovf),      '0);
`endif
  endtask

  // Called at a negedge in IDLE. Start is held for one edge; extra start
  // pulses are injected in cycles p1/p2 (0 = none) with junk operands.
  task automatic run_vec(input string name, input word_t a, input word_t b, input logic cin,
                         input word_t exp_r, input logic exp_c, input int p1, input int p2);
    int cyc;
    cyc = -1;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.c_in  = cin;
    @(negedge clk);
    for (int c = 1; c <= BUDGET; c++) begin
      if (c == 1) begin
        check({name, "_busy_c1"},  TW'(bus.busy),     TW'(1));
        check({name, "_add_a_c1"}, TW'(bus.add_a),    TW'(a[W-1:0]));
        check({name, "_add_b_c1"}, TW'(bus.add_b),    TW'(b[W-1:0]));
        check({name, "_cin_c1"},   TW'(bus.add_c_in), TW'(cin));
      end
      if (c == 2) begin
        check({name, "_add_a_hold"}, TW'(bus.add_a), TW'(a[W-1:0]));
      end
      if (bus.done) begin
        cyc = c;
        break;
      end
      bus.start = (c == p1) || (c == p2);
      bus.op_a  = word_t'({$urandom(), $urandom()});
      bus.op_b  = word_t'({$urandom(), $urandom()});
      bus.c_in  = 1'($urandom());
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, "_latency"}, TW'(cyc), TW'(EXP_LAT));
    check({name, "_result"},  bus.result, exp_r);
    check({name, "_c_out"},   TW'(bus.c_out), TW'(exp_c));
`ifdef WIDE_ADD_OVF_EN
    check({name, "_ovf"},     TW'(bus.ovf), TW'(model_ovf(a, b, cin)));
`endif
    @(negedge clk);
    check({name, "_done_pulse"}, TW'(bus.done), '0);
    check({name, "_idle"},       TW'(bus.busy), '0);
    check({name, "_held"},       bus.result,    exp_r);
  endtask

  initial begin
    vec_t vecs [NVEC];
    int   done_cnt;

    vecs[0] = '{a: 64'h0000_0000_0000_0001, b: 64'h0000_0000_0000_0002, cin: 1'b0,
                exp_r: 64'h0000_0000_0000_0003, exp_c: 1'b0};
    vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0000_0000_0000_0000, cin: 1'b1,
                exp_r: 64'h0000_0000_0000_0000, exp_c: 1'b1};
    vecs[2] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b0,
                exp_r: 64'hFFFF_FFFF_FFFF_FFFE, exp_c: 1'b1};
    vecs[3] = '{a: 64'h0000_0000_0000_FFFF, b: 64'h0000_0000_0000_0001, cin: 1'b0,
                exp_r: 64'h0000_0000_0001_0000, exp_c: 1'b0};
    vecs[4] = '{a: 64'h0000_0000_0000_0000, b: 64'h0000_0000_0000_0000, cin: 1'b1,
                exp_r: 64'h0000_0000_0000_0001, exp_c: 1'b0};
    vecs[5] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, cin: 1'b0,
                exp_r: 64'h2222_2222_2222_2211, exp_c: 1'b0};
    vecs[6] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h0000_0000_0000_0001, cin: 1'b0,
                exp_r: 64'h8000_0000_0000_0000, exp_c: 1'b0};
    vecs[7] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0,
                exp_r: 64'h0000_0000_0000_0000, exp_c: 1'b1};

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.c_in  = 1'b0;

    // Reset held for three cycles, then released.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("reset");
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
    end
    check("reset_no_done", TW'(done_cnt), '0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
              vecs[i].exp_r, vecs[i].exp_c, 0, 0);
`ifdef WIDE_ADD_OVF_EN
      if (i >= 6) begin
        check($sformatf("vec%0d_ovf_spec", i), TW'(bus.ovf), TW'(1));
      end
`endif
    end

    // Start pulses during cycles 2 and 8 must be ignored, not queued.
    run_vec("ignore", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0,
            64'h0000_0000_0000_000C, 1'b0, 2, 8);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      done_cnt += int'(bus.done) + int'(bus.busy);
    end
    check("ignore_no_requeue", TW'(done_cnt), '0);
    run_vec("after_ignore", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1,
            64'h0000_0000_0000_0031, 1'b0, 0, 0);

    // Reset during WAIT of slice 2 (cycle 6 after start).
    bus.start = 1'b1;
    bus.op_a  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.op_b  = 64'h0000_0000_0000_0001;
    bus.c_in  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", TW'(bus.busy), TW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("mid_rst_rel");
    run_vec("post_rst", 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001, 1'b0,
            64'h0000_0000_0000_1235, 1'b0, 0, 0);

    // Randomized adds, biased toward long carry chains every few vectors.
    for (int i = 0; i < 24; i++) begin
      word_t       ra;
      word_t       rb;
      logic        rc;
      logic [TW:0] m;
      ra = word_t'({$urandom(), $urandom()});
      rb = word_t'({$urandom(), $urandom()});
      rc = 1'($urandom());
      if (i % 4 == 0) begin
        ra = '1;
        rb = word_t'($urandom_range(0, 3));
      end
      m = model_add(ra, rb, rc);
      run_vec($sformatf("rand%0d", i), ra, rb, rc, m[TW-1:0], m[TW], 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word carry-chain sequencer placed directly around `adder_top`. It accepts an N×W-bit add request and streams W-bit operand slices into the adder, least significant slice first. Each slice's `c_out` becomes the next slice's `c_in`. It reassembles the returned `sum` slices into one N×W-bit result. This gives 64-bit and wider adds on the existing 16-bit registered adder without widening it.

## Interface
- `W`, 16: adder slice width; must match `adder_top` `W`.
- `N`, 4: number of slices; N ≥ 1; total width N×W.
- `LAT`, 1: `adder_top` latency in clock cycles from operand change to registered `sum`/`c_out`; LAT ≥ 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request strobe; sampled only in IDLE.
- `op_a` in N×W: operand A; latched on accepted `start`.
- `op_b` in N×W: operand B; latched on accepted `start`.
- `c_in` in 1: carry into slice 0; latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse; `result`/`c_out` valid from this cycle onward.
- `result` out N×W: assembled sum; held until next accepted `start`.
- `c_out` out 1: carry out of slice N-1; held with `result`.
- `add_a` out W: to `adder_top.a`.
- `add_b` out W: to `adder_top.b`.
- `add_c_in` out 1: to `adder_top.c_in`.
- `add_sum` in W: from `adder_top.sum`.
- `add_c_out` in 1: from `adder_top.c_out`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- IDLE, `start`=1:
  - Latch `op_a`, `op_b`, `c_in`.
  - Slice index k ← 0; clear `result` and `c_out`.
  - Go to ISSUE.
- IDLE, `start`=0: stay in IDLE.
- ISSUE:
  - Drive `add_a`=A[k], `add_b`=B[k], `add_c_in`=carry register (slice 0 uses the latched `c_in`).
  - Load wait counter with LAT.
  - Go to WAIT.
- WAIT:
  - Hold the ISSUE-cycle `add_a`/`add_b`/`add_c_in` values stable.
  - Decrement the counter.
  - On the last WAIT cycle (counter = 1), capture `add_sum` → `result[k]` and `add_c_out` → carry register.
  - Then: if k = N-1, go to DONE; otherwise k ← k+1 and go to ISSUE.
- DONE:
  - `done`=1 for one cycle.
  - `c_out` ← final carry.
  - Go to IDLE.
- `start` in ISSUE, WAIT or DONE is ignored; it is not queued.
- Operand inputs are don't-care except in the cycle where `start` is accepted.
- Arithmetic is unsigned modulo 2^(N×W). `c_out` is the carry out of bit N×W-1.
- Reset mid-operation: return to IDLE next edge. All outputs return to reset values. Any in-flight adder result is discarded; the adder's own pipeline needs no flush.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `c_out`=0, `add_a`=0, `add_b`=0, `add_c_in`=0.
- Per slice: 1 ISSUE + LAT WAIT cycles = LAT+1 cycles.
- Latency: `start` sampled at edge E0 → `done` high during cycle N×(LAT+1)+1 after E0. Default: 9 cycles.
- Throughput: one request per N×(LAT+1)+2 cycles (adds one IDLE cycle).
- N=1: a single ISSUE/WAIT pass. `c_out` equals the adder's `c_out`.
- `add_*` outputs retain their last values in IDLE/DONE; the adder result is ignored there.

## Configuration
- `WIDE_ADD_OVF_EN` defined:
  - Adds output port `ovf` (1 bit) = two's-complement signed overflow of the full N×W add, i.e. (A msb == B msb) && (result msb != A msb).
  - `ovf` is registered with `c_out`, valid from `done`, and resets to 0.
- `WIDE_ADD_OVF_EN` undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Structure
- Package `wide_add_pkg` holds:
  - the state enum/localparams (IDLE, ISSUE, WAIT, DONE);
  - a slice-index width function ($clog2(N), minimum 1);
  - the wait-counter width ($clog2(LAT+1)).
- One natural sub-module: `wide_add_slice_regs`, the N×W operand/result slice register file with indexed read (A[k], B[k]) and indexed write (result[k]). The FSM and counters stay in the top module.
- Bench instantiates `adder_top` (W=16) wired to the `add_*` ports.

## Test plan
- Reset held 3 cycles, then released → all outputs 0; `busy`=0; no `done`.
- A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0002, `c_in`=0 → `result`=0x0000_0000_0000_0003, `c_out`=0; `done` exactly 9 cycles after `start`.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0000, `c_in`=1 → `result`=0, `c_out`=1 (full carry ripple across all 4 slices).
- `start` pulsed again at cycles 2 and 8 of an operation → ignored. First result is correct, and the second `done` appears only after a new `start` in IDLE.
- `rst_n` asserted in WAIT of slice 2 → next cycle all outputs 0 and FSM in IDLE. A following add of 0x1234 + 0x1 gives 0x1235 with no corruption.
- `WIDE_ADD_OVF_EN`: A=0x7FFF_FFFF_FFFF_FFFF, B=1 → `ovf`=1, `result`=0x8000_0000_0000_0000, `c_out`=0. Then A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000 → `ovf`=1, `result`=0, `c_out`=1.
